// File: rtl/odd_count_sequencer_if.sv
// Configuration handshake bundle for odd_count_sequencer.
// Valid/ready: a config word transfers on any rising edge where cfg_valid and cfg_ready are both high.
interface odd_count_sequencer_if #(
  parameter int WIDTH = 8
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_start;
  logic [WIDTH-1:0] cfg_step;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_wrap;

  modport master (
    output cfg_valid, cfg_start, cfg_step, cfg_limit, cfg_wrap,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_start, cfg_step, cfg_limit, cfg_wrap,
    output cfg_ready
  );
endinterface

// File: rtl/odd_count_sequencer.sv
// Programmable start/step/limit counter with configure, run, pause, abort and wrap/one-shot end.
// Every output is a register or a Moore decode of the state register.
module odd_count_sequencer #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_START = WIDTH'('h01),
  parameter logic [WIDTH-1:0] RST_STEP  = WIDTH'('h02),
  parameter logic [WIDTH-1:0] RST_LIMIT = WIDTH'('hFF)
) (
  input  logic                  clk,
  input  logic                  reset,
  odd_count_sequencer_if.slave  cfg,
  input  logic                  go,
  input  logic                  pause,
  input  logic                  abort,
  output logic [WIDTH-1:0]      cnt_o,
  output logic                  cnt_valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  logic             ready;
  logic             cfg_fire;
  logic [WIDTH:0]   nxt;
  logic             term;

  assign ready    = (state_q == S_IDLE) || (state_q == S_ARMED) || (state_q == S_DONE);
  assign cfg_fire = cfg.cfg_valid && ready;
  // One extra bit so a carry out of the count also reads as "past the limit".
  assign nxt      = {1'b0, cnt_q} + {1'b0, step_q};
  assign term     = nxt > {1'b0, limit_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= RST_START;
      start_q <= RST_START;
      step_q  <= RST_STEP;
      limit_q <= RST_LIMIT;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      step_q  <= step_d;
      limit_q <= limit_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    step_d  = step_q;
    limit_d = limit_q;
    wrap_d  = wrap_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = start_q;
    end else if (cfg_fire) begin
      start_d = cfg.cfg_start;
      step_d  = cfg.cfg_step;
      limit_d = cfg.cfg_limit;
      wrap_d  = cfg.cfg_wrap;
      cnt_d   = cfg.cfg_start;
      state_d = S_ARMED;
    end else if (go && ready) begin
      cnt_d   = start_q;
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          // The shown value is consumed this cycle, so the advance happens even when pausing.
          if (term && !wrap_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = term ? start_q : nxt[WIDTH-1:0];
            state_d = pause ? S_HOLD : S_RUN;
          end
        end
        S_HOLD: begin
          if (!pause) state_d = S_RUN;
        end
        default: ;
      endcase
    end
  end

  assign cnt_o         = cnt_q;
  assign cnt_valid_o   = (state_q == S_RUN);
  assign busy_o        = (state_q == S_RUN) || (state_q == S_HOLD);
  assign done_o        = done_q;
  assign cfg.cfg_ready = ready;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/odd_count_sequencer.md
Name: odd_count_sequencer

Overview:
Controller that sequences an 8-bit stepping counter (the odd-counter datapath generalised to a programmable start, step and limit). It accepts a configuration through a valid/ready handshake, then runs the count on a `go` command. It supports pause/resume, abort, and wrap or one-shot termination. It sits between the control/CSR logic and downstream consumers of the count stream, presenting one valid count per run cycle.

Parameters:
WIDTH, 8, count and configuration width
RST_START, 8'h01, start value after reset
RST_STEP, 8'h02, step value after reset
RST_LIMIT, 8'hFF, limit value after reset

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration can be accepted
cfg_start  input  WIDTH  first count value
cfg_step  input  WIDTH  increment per advance
cfg_limit  input  WIDTH  highest legal count value (inclusive)
cfg_wrap  input  1  1 = restart at start past limit; 0 = one-shot
go  input  1  start counting
pause  input  1  level; hold the count while high
abort  input  1  return to IDLE immediately
cnt_o  output  WIDTH  current count
cnt_valid_o  output  1  cnt_o is a new sequence value this cycle
busy_o  output  1  state is RUN or HOLD
done_o  output  1  one-cycle pulse at one-shot completion

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- States: IDLE, ARMED, RUN, HOLD, DONE. All outputs are registered or Moore-decoded from state.
- Reset values: state IDLE; cnt_o = RST_START; config registers = RST_START/RST_STEP/RST_LIMIT, wrap = 0; cnt_valid_o = 0, busy_o = 0, done_o = 0, cfg_ready = 1.
- Priority per cycle: reset > abort > cfg handshake > go > pause.
- cfg_ready = 1 in IDLE, ARMED and DONE; 0 in RUN and HOLD.
- Handshake (cfg_valid & cfg_ready):
  - Latches all cfg_* fields.
  - Next cycle: cnt_o = cfg_start, state ARMED.
  - A go in the same cycle is ignored.
- go in IDLE/ARMED/DONE with no handshake that cycle:
  - Next cycle: state RUN, cnt_o = latched start.
  - go in RUN/HOLD is ignored.
- RUN:
  - cnt_valid_o = 1 every RUN cycle.
  - Each RUN cycle computes nxt = cnt_o + step at WIDTH+1 bits. Terminal when nxt > limit; this comparison also catches carry-out.
  - Non-terminal: cnt_o <= nxt[WIDTH-1:0].
  - Terminal with wrap = 1: cnt_o <= start, stay RUN.
  - Terminal with wrap = 0: cnt_o holds, state -> DONE.
- Pause:
  - pause = 1 in RUN: the current value is still consumed (valid = 1) and the counter still advances. State -> HOLD, unless the advance is terminal one-shot, which goes to DONE.
  - HOLD: cnt_o frozen, cnt_valid_o = 0, busy_o = 1.
  - pause = 0 in HOLD -> RUN next cycle.
  - Each sequence value is presented valid exactly once.
- DONE:
  - done_o = 1 only on the first cycle in DONE.
  - cnt_o holds the last value; state stays DONE until go, handshake or abort.
- abort in ARMED/RUN/HOLD/DONE:
  - Next cycle: IDLE, cnt_o = latched start, cnt_valid_o = 0.
  - done_o is never asserted by an abort.
- Degenerate configurations:
  - step = 0: legal; cnt_o repeats start every RUN cycle, terminal only if start > limit.
  - start > limit: one valid cycle showing start, then terminal handling.
- Reset mid-operation: behaves exactly as power-up reset; configuration returns to RST_* values.

Test Plan:
1. Reset, then go with default config -> 128 valid values 8'h01, 8'h03 … 8'hFF. Next cycle done_o pulses for 1 cycle and cnt_o holds 8'hFF (9-bit compare catches the 257 overflow).
2. Handshake start 4, step 3, limit 16, wrap 0, then go -> valid 4, 7, 10, 13, 16; then DONE with done_o = 1 for one cycle and cnt_o = 16.
3. Handshake start 0, step 5, limit 12, wrap 1, then go -> 0, 5, 10, 0, 5, 10 …; done_o never asserts.
4. Default run with pause high for 3 cycles after value 5 -> 5 valid once, cnt_o = 7 frozen with valid = 0 for 3 cycles, then 7 valid once, 9 …; no value is skipped or duplicated.
5. abort in HOLD -> IDLE next cycle, cnt_o = start, no done_o. Separately, reset mid-RUN -> cnt_o = 8'h01, all flags 0.
6. cfg_valid during RUN -> cfg_ready = 0 and the count is unaffected. cfg_valid together with go in IDLE -> config latched, state ARMED, no counting until a later go.
